// File: rtl/pkt_buf_ram.sv
// Single-clock packet buffer: fills one package of PKT_LEN words sequentially,
// then serves bounds-checked random-access reads with a one-cycle latency.
module pkt_buf_ram #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 5,
    parameter int PKT_LEN = 32
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              pkt_release,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              rd_err,
    output logic              package_full,
    output logic [ADDR_W:0]   wr_count,
    output logic              overflow
);

    localparam int DEPTH = 2 ** ADDR_W;

    if (PKT_LEN < 1 || PKT_LEN > DEPTH) begin : g_bad_pkt_len
        $error("pkt_buf_ram: PKT_LEN must be in 1..2**ADDR_W");
    end

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(PKT_LEN - 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    // Handshake: wr_en, rd_en and pkt_release are single-cycle requests with no
    // ready/back-pressure; only a clean 1 counts, X/Z are treated as idle.
    logic wr_req;
    logic rd_req;
    logic rel_req;
    assign wr_req  = (wr_en === 1'b1);
    assign rd_req  = (rd_en === 1'b1);
    assign rel_req = (pkt_release === 1'b1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic do_write;
    logic last_write;
    logic rd_legal;

    // Release always wins over a same-cycle write.
    assign do_write   = wr_req && !rel_req && (state == ST_FILL);
    assign last_write = do_write && (wr_count == LAST_CNT);
    // Legality uses the count before this edge, so the word being written now
    // is not yet readable.
    assign rd_legal   = rd_req && ({1'b0, rd_addr} < wr_count);

    // The package_full output is the FSM state itself.
    assign package_full = (state == ST_FULL);

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state    <= ST_FILL;
            wr_ptr   <= '0;
            wr_count <= '0;
            overflow <= 1'b0;
        end else if (rel_req) begin
            state    <= ST_FILL;
            wr_ptr   <= '0;
            wr_count <= '0;
            overflow <= 1'b0;
        end else if (do_write) begin
            wr_count <= wr_count + (ADDR_W + 1)'(1);
            if (last_write) begin
                state <= ST_FULL;
            end else begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
        end else if (wr_req && state == ST_FULL) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_write) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            data_valid <= rd_legal;
            rd_err     <= rd_req && !rd_legal;
            if (rd_legal) begin
                data_out <= mem[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_pkt_buf_ram.sv
// Directed bench for pkt_buf_ram: default 8x32 instance plus a 16-bit,
// 8-deep instance with PKT_LEN=6 for the mid-read reset case.
module tb_pkt_buf_ram;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Default instance
    logic        rst;
    logic [7:0]  data_in;
    logic        wr_en, rd_en, pkt_release;
    logic [4:0]  rd_addr;
    logic [7:0]  data_out;
    logic        data_valid, rd_err, package_full, overflow;
    logic [5:0]  wr_count;

    // Small parametrised instance
    logic        rst_b;
    logic [15:0] data_in_b;
    logic        wr_en_b, rd_en_b, pkt_release_b;
    logic [2:0]  rd_addr_b;
    logic [15:0] data_out_b;
    logic        data_valid_b, rd_err_b, package_full_b, overflow_b;
    logic [3:0]  wr_count_b;

    pkt_buf_ram dut (
        .clk_in(clk_in), .rst(rst), .data_in(data_in), .wr_en(wr_en),
        .rd_en(rd_en), .rd_addr(rd_addr), .pkt_release(pkt_release),
        .data_out(data_out), .data_valid(data_valid), .rd_err(rd_err),
        .package_full(package_full), .wr_count(wr_count), .overflow(overflow)
    );

    pkt_buf_ram #(.DATA_W(16), .ADDR_W(3), .PKT_LEN(6)) dut_b (
        .clk_in(clk_in), .rst(rst_b), .data_in(data_in_b), .wr_en(wr_en_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .pkt_release(pkt_release_b),
        .data_out(data_out_b), .data_valid(data_valid_b), .rd_err(rd_err_b),
        .package_full(package_full_b), .wr_count(wr_count_b), .overflow(overflow_b)
    );

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_a();
        wr_en = 1'bz; rd_en = 1'bz; pkt_release = 1'bz;
    endtask

    task automatic idle_b();
        wr_en_b = 1'bz; rd_en_b = 1'bz; pkt_release_b = 1'bz;
    endtask

    task automatic write_a(input logic [7:0] d);
        wr_en = 1'b1; data_in = d;
        step();
        wr_en = 1'bz;
    endtask

    task automatic read_a(input logic [4:0] a);
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'bz;
    endtask

    initial begin
        data_in = '0; rd_addr = '0; data_in_b = '0; rd_addr_b = '0;
        idle_a();
        idle_b();

        // 1. Reset with idle control lines
        rst = 1'b0; rst_b = 1'b0;
        #500;
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_rd_err", 32'(rd_err), 32'h0);
        check("rst_package_full", 32'(package_full), 32'h0);
        check("rst_wr_count", 32'(wr_count), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_b_wr_count", 32'(wr_count_b), 32'h0);
        rst = 1'b1; rst_b = 1'b1;
        step();
        step();
        check("post_rst_wr_count", 32'(wr_count), 32'h0);
        check("post_rst_data_valid", 32'(data_valid), 32'h0);
        check("post_rst_rd_err", 32'(rd_err), 32'h0);

        // 2. Fill 9 words 0x56..0x5E and read back 1..5
        for (int i = 0; i < 9; i++) write_a(8'(8'h56 + i));
        check("fill9_wr_count", 32'(wr_count), 32'd9);
        check("fill9_package_full", 32'(package_full), 32'h0);
        for (int a = 1; a <= 5; a++) begin
            exp_q.push_back(16'(8'h56 + a));
            read_a(5'(a));
            check("rd_valid", 32'(data_valid), 32'h1);
            check("rd_data", 32'(data_out), 32'(exp_q.pop_front()));
        end
        step();
        check("rd_valid_drops", 32'(data_valid), 32'h0);

        // 3. Illegal reads at the boundary and far beyond
        read_a(5'd9);
        check("ill9_rd_err", 32'(rd_err), 32'h1);
        check("ill9_valid", 32'(data_valid), 32'h0);
        check("ill9_data_hold", 32'(data_out), 32'h5B);
        read_a(5'd20);
        check("ill20_rd_err", 32'(rd_err), 32'h1);
        check("ill20_data_hold", 32'(data_out), 32'h5B);
        step();
        check("rd_err_pulse", 32'(rd_err), 32'h0);

        // Read the address being written: illegal; next cycle it is readable
        wr_en = 1'b1; data_in = 8'h5F; rd_en = 1'b1; rd_addr = 5'd9;
        step();
        check("rdw_same_rd_err", 32'(rd_err), 32'h1);
        check("rdw_same_wr_count", 32'(wr_count), 32'd10);
        data_in = 8'h60;
        step();
        idle_a();
        check("rdw_prev_valid", 32'(data_valid), 32'h1);
        check("rdw_prev_data", 32'(data_out), 32'h5F);
        check("rdw_wr_count", 32'(wr_count), 32'd11);

        // 4. Fill to 32 words, then overflow
        for (int i = 11; i < 31; i++) write_a(8'(8'h56 + i));
        check("w31_package_full", 32'(package_full), 32'h0);
        write_a(8'h75);
        check("w32_package_full", 32'(package_full), 32'h1);
        check("w32_wr_count", 32'(wr_count), 32'd32);
        check("w32_overflow", 32'(overflow), 32'h0);
        write_a(8'hAA);
        check("ovf_overflow", 32'(overflow), 32'h1);
        check("ovf_wr_count", 32'(wr_count), 32'd32);
        step();
        check("ovf_sticky", 32'(overflow), 32'h1);
        read_a(5'd0);
        check("ovf_ram0", 32'(data_out), 32'h56);
        read_a(5'd31);
        check("full_rd31", 32'(data_out), 32'h75);

        // 5. Release with a simultaneous write and a read of the last word
        pkt_release = 1'b1; wr_en = 1'b1; data_in = 8'hBB; rd_en = 1'b1; rd_addr = 5'd30;
        step();
        idle_a();
        check("rel_package_full", 32'(package_full), 32'h0);
        check("rel_overflow", 32'(overflow), 32'h0);
        check("rel_wr_count", 32'(wr_count), 32'h0);
        check("rel_rd_valid", 32'(data_valid), 32'h1);
        check("rel_rd_data", 32'(data_out), 32'h74);
        step();
        check("rel_write_dropped", 32'(wr_count), 32'h0);
        read_a(5'd0);
        check("rel_rd0_err", 32'(rd_err), 32'h1);

        // Abort a partial package
        write_a(8'h11);
        write_a(8'h22);
        check("part_wr_count", 32'(wr_count), 32'd2);
        pkt_release = 1'b1;
        step();
        idle_a();
        check("abort_wr_count", 32'(wr_count), 32'h0);
        write_a(8'h33);
        read_a(5'd0);
        check("abort_new_data", 32'(data_out), 32'h33);

        // 6. Parametrised instance: 6 words, reset mid-read
        for (int i = 0; i < 6; i++) begin
            wr_en_b = 1'b1; data_in_b = 16'(16'h1000 + i * 16'h0111);
            step();
            if (i == 4) check("b_w5_package_full", 32'(package_full_b), 32'h0);
        end
        idle_b();
        check("b_package_full", 32'(package_full_b), 32'h1);
        check("b_wr_count", 32'(wr_count_b), 32'd6);
        rd_en_b = 1'b1; rd_addr_b = 3'd5;
        step();
        check("b_rd5_valid", 32'(data_valid_b), 32'h1);
        check("b_rd5_data", 32'(data_out_b), 32'h1555);
        rd_addr_b = 3'd2;
        #2;
        rst_b = 1'b0;
        #1;
        check("b_arst_package_full", 32'(package_full_b), 32'h0);
        check("b_arst_data_valid", 32'(data_valid_b), 32'h0);
        check("b_arst_wr_count", 32'(wr_count_b), 32'h0);
        check("b_arst_data_out", 32'(data_out_b), 32'h0);
        idle_b();
        #3;
        rst_b = 1'b1;
        step();
        check("b_post_rst_wr_count", 32'(wr_count_b), 32'h0);
        check("b_post_rst_valid", 32'(data_valid_b), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pkt_buf_ram.md
Name: pkt_buf_ram

Overview:
- Parametrised single-clock packet buffer: successor to the fixed 8-bit x 32-word PLL/RAM datapath.
- Sequentially writes one package of PKT_LEN words and flags package_full.
- Serves random-access reads with 1-cycle latency, a valid strobe and an address error check.
- Adds explicit package release/abort, a live fill count and sticky overflow detection.
- Sits downstream of the clock generator: clk_in is the already-locked system clock; no PLL inside.

Parameters:
- DATA_W, 8: data word width.
- ADDR_W, 5: address width; storage depth is 2**ADDR_W words.
- PKT_LEN, 32: words per package. Must satisfy 1 <= PKT_LEN <= 2**ADDR_W; elaboration error otherwise.

Ports:
- clk_in, input, 1: sole clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- data_in, input, DATA_W: write data.
- wr_en, input, 1: write request for the current cycle.
- rd_en, input, 1: read request for the current cycle.
- rd_addr, input, ADDR_W: read address.
- pkt_release, input, 1: frees the current package (or aborts a partial one).
- data_out, output, DATA_W: read data, registered.
- data_valid, output, 1: data_out updated by a legal read; 1-cycle pulse.
- rd_err, output, 1: illegal read attempted; 1-cycle pulse.
- package_full, output, 1: package complete, writes blocked.
- wr_count, output, ADDR_W+1: number of words written in the current package, 0..PKT_LEN.
- overflow, output, 1: sticky; a write was attempted while full.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FILL, wr_ptr=0, wr_count=0.
  - package_full=0, overflow=0, data_valid=0, rd_err=0, data_out=0.
  - RAM contents are not cleared.
- Input sampling: wr_en, rd_en and pkt_release count as asserted only when exactly 1; 0, X and Z are all deasserted. Benches drive these to Z when idle.
- FILL state:
  - wr_en=1 writes data_in to RAM[wr_ptr]; wr_ptr and wr_count increment at the same edge.
  - When the write takes wr_count to PKT_LEN, the next state is FULL. package_full=1 from the cycle after the last write.
- FULL state:
  - wr_en=1 does not write and does not change wr_ptr or wr_count; overflow is set to 1.
  - overflow stays at 1 until pkt_release or reset.
- pkt_release=1, in any state: next cycle state=FILL, wr_ptr=0, wr_count=0, package_full=0, overflow=0.
  - In FILL this aborts the partial package.
  - If wr_en is asserted in the same cycle, the release wins and the write is dropped.
- Reads, in any state:
  - Legal read: rd_en=1 and rd_addr < wr_count, using the wr_count value before this edge. Next cycle data_out=RAM[rd_addr] and data_valid=1.
  - Illegal read: next cycle rd_err=1, data_valid=0, data_out holds its previous value.
- Read/write same cycle:
  - If rd_addr equals the address being written, the read is illegal because wr_count is not yet updated.
  - Read-during-write to other addresses is unaffected.
- Read coinciding with pkt_release: legality is evaluated against the pre-release wr_count and the read completes normally.
- wr_ptr never wraps within a package; it is returned to 0 only by release or reset.
- Reset asserted mid-package: all state is discarded immediately, as in the reset clause; outputs follow reset values asynchronously.

Test Plan:
1. Reset: hold rst=0 for 500 ns with wr_en/rd_en at Z -> all outputs 0, wr_count=0. Release rst -> no spurious write or read.
2. Fill and read back: write 0x56..0x5E (9 words) -> wr_count=9, package_full=0. Read addresses 1..5 -> data_out=0x57..0x5B, each with data_valid one cycle after rd_en.
3. Illegal read: with wr_count=9, read address 9 and then 20 -> rd_err pulses twice, data_valid=0, data_out unchanged.
4. Full and overflow: write 32 words (PKT_LEN=32) -> package_full=1 on the cycle after the 32nd write. A 33rd write -> overflow=1, wr_count stays 32, RAM[0] unchanged.
5. Release: in FULL, assert pkt_release together with wr_en -> next cycle package_full=0, overflow=0, wr_count=0. The simultaneous write is dropped (wr_count does not become 1).
6. Parametrised instance: DATA_W=16, ADDR_W=3, PKT_LEN=6. Write 6 words, then pulse rst=0 mid-read -> package_full=1 after the 6th write; the reset clears package_full, data_valid and wr_count immediately.
